// File: rtl/pintest_checker.sv
// Tester-side walking-one pin checker: drives test_clock into the DUT board and checks 16 sense lines per step.
// Optional build macro PINTEST_CHECKER_STOP_ON_ERROR_EN ends the run at the first mismatching step.
module pintest_checker #(
  parameter int PINCOUNT      = 128,
  parameter int GROUP_WIDTH   = 16,
  parameter int RESET_CYCLES  = 300_000_000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int HIGH_CYCLES   = 100,
  parameter logic [PINCOUNT-1:0] SKIP_MASK = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [GROUP_WIDTH-1:0]                 sense,
  output logic                                   test_clock,
  output logic [$clog2(PINCOUNT/GROUP_WIDTH)-1:0] grp_sel,
  output logic [$clog2(PINCOUNT)-1:0]            step,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   pass,
  output logic [7:0]                             err_count,
  output logic [$clog2(PINCOUNT)-1:0]            first_err_step,
  output logic [GROUP_WIDTH-1:0]                 first_err_data
);

  localparam int STEP_W  = $clog2(PINCOUNT);
  localparam int GRP_W   = $clog2(PINCOUNT / GROUP_WIDTH);
  localparam int MAX_A   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > HIGH_CYCLES) ? MAX_A : HIGH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

`ifdef PINTEST_CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERROR = 1'b1;
`else
  localparam bit STOP_ON_ERROR = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DUT_RST, SETTLE, SAMPLE, CLK_HI, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STEP_W-1:0]      step_d, first_err_step_d;
  logic [7:0]             err_count_d, err_inc;
  logic [GROUP_WIDTH-1:0] first_err_data_d, exp_pat, sense_meta, sense_sync;
  logic                   test_clock_d, busy_d, done_d, pass_d, mismatch, finish;

  // Sense lines are asynchronous to clk; settle time covers the two-stage latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      sense_meta <= '0;
      sense_sync <= '0;
    end else begin
      sense_meta <= sense;
      sense_sync <= sense_meta;
    end
  end

  assign grp_sel  = GRP_W'(32'(step) / GROUP_WIDTH);
  assign exp_pat  = SKIP_MASK[step] ? '0 : (GROUP_WIDTH'(1) << (32'(step) % GROUP_WIDTH));
  assign mismatch = (sense_sync != exp_pat);
  assign err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      step           <= '0;
      err_count      <= '0;
      first_err_step <= '0;
      first_err_data <= '0;
      test_clock     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step           <= step_d;
      err_count      <= err_count_d;
      first_err_step <= first_err_step_d;
      first_err_data <= first_err_data_d;
      test_clock     <= test_clock_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    step_d           = step;
    err_count_d      = err_count;
    first_err_step_d = first_err_step;
    first_err_data_d = first_err_data;
    test_clock_d     = test_clock;
    busy_d           = busy;
    done_d           = done;
    pass_d           = pass;
    finish           = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d          = DUT_RST;
          cnt_d            = CNT_W'(RESET_CYCLES - 1);
          step_d           = '0;
          err_count_d      = '0;
          first_err_step_d = '0;
          first_err_data_d = '0;
          test_clock_d     = 1'b0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
        end
      end
      DUT_RST: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_inc;
          if (err_count == 8'd0) begin
            first_err_step_d = step;
            first_err_data_d = sense_sync;
          end
        end
        finish = (step == STEP_W'(PINCOUNT - 1)) || (STOP_ON_ERROR && mismatch);
        if (finish) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 8'd0);
        end else begin
          state_d      = CLK_HI;
          test_clock_d = 1'b1;
          cnt_d        = CNT_W'(HIGH_CYCLES - 1);
        end
      end
      CLK_HI: begin
        // The falling edge and the step advance happen together so the mux tracks the DUT.
        if (cnt_q == '0) begin
          state_d      = SETTLE;
          test_clock_d = 1'b0;
          step_d       = step + 1'b1;
          cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pintest_checker.sv
// Bench for pintest_checker: a walking-one DUT-board model with injectable faults drives two checkers
// (no skip mask / skip mask bit 23); a scoreboard compares each finished run with a reference result.
module tb_pintest_checker;

  typedef struct {
    int errs;
    int first_step;
    int first_data;
    int pass;
    int edges;
    int final_step;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sense_w [2];
  logic        test_clock_w [2];
  logic [2:0]  grp_sel_w [2];
  logic [6:0]  step_w [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic [7:0]  err_count_w [2];
  logic [6:0]  first_err_step_w [2];
  logic [15:0] first_err_data_w [2];

  int checks = 0;
  int fails  = 0;

  logic [127:0] stuck_mask = '0;
  int           short_a = -1;
  int           short_b = -1;
  logic [127:0] skip1;

  exp_t sb_q0 [$];
  exp_t sb_q1 [$];

  int   model_pos [2];
  int   model_low [2];
  logic model_prev [2];
  int   edges [2];
  logic mon_prev [2];
  logic done_seen [2];

  always #5 clk = ~clk;

  pintest_checker #(
    .PINCOUNT(128), .GROUP_WIDTH(16), .RESET_CYCLES(20), .SETTLE_CYCLES(4), .HIGH_CYCLES(3),
    .SKIP_MASK(128'h0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .sense(sense_w[0]),
    .test_clock(test_clock_w[0]), .grp_sel(grp_sel_w[0]), .step(step_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_count_w[0]),
    .first_err_step(first_err_step_w[0]), .first_err_data(first_err_data_w[0])
  );

  pintest_checker #(
    .PINCOUNT(128), .GROUP_WIDTH(16), .RESET_CYCLES(20), .SETTLE_CYCLES(4), .HIGH_CYCLES(3),
    .SKIP_MASK(128'h0000_0000_0000_0000_0000_0000_0080_0000)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .sense(sense_w[1]),
    .test_clock(test_clock_w[1]), .grp_sel(grp_sel_w[1]), .step(step_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_count_w[1]),
    .first_err_step(first_err_step_w[1]), .first_err_data(first_err_data_w[1])
  );

  // Pin levels the faulty board shows while its walking one sits at position p.
  function automatic logic [127:0] model_word(input int p);
    logic [127:0] w;
    w = '0;
    if (p >= 0 && p < 128) w[p] = 1'b1;
    if (short_a >= 0 && short_b >= 0 && (p == short_a || p == short_b)) begin
      w[short_a] = 1'b1;
      w[short_b] = 1'b1;
    end
    return w & ~stuck_mask;
  endfunction

  // Expected end-of-run result derived step by step from the walking-one rules.
  function automatic exp_t ref_run(input logic [127:0] skip);
    exp_t        e;
    logic [127:0] w;
    logic [15:0] sensed, expv, one16;
    e.errs = 0; e.first_step = 0; e.first_data = 0; e.edges = 127; e.final_step = 127;
    one16 = 16'h0001;
    for (int s = 0; s < 128; s++) begin
      w      = model_word(s);
      sensed = w[(s / 16) * 16 +: 16];
      expv   = skip[s] ? 16'h0000 : (one16 << (s % 16));
      if (sensed != expv) begin
        if (e.errs == 0) begin
          e.first_step = s;
          e.first_data = int'(sensed);
        end
        e.errs = (e.errs < 255) ? e.errs + 1 : 255;
`ifdef PINTEST_CHECKER_STOP_ON_ERROR_EN
        e.edges = s;
        e.final_step = s;
        break;
`endif
      end
    end
    e.pass = (e.errs == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Board model: the walking one advances on each test_clock rise and a long low time resets it.
  always @(negedge clk) begin
    logic [127:0] w;
    for (int g = 0; g < 2; g++) begin
      if (test_clock_w[g] === 1'b1 && model_prev[g] !== 1'b1) model_pos[g]++;
      if (test_clock_w[g] === 1'b1) model_low[g] = 0;
      else                          model_low[g]++;
      if (model_low[g] >= 12) model_pos[g] = 0;
      model_prev[g] = test_clock_w[g];
      w = model_word(model_pos[g]);
      sense_w[g] = (grp_sel_w[g] === 3'bxxx) ? 16'h0 : w[int'(grp_sel_w[g]) * 16 +: 16];
    end
  end

  // Scoreboard monitor: one expected result is consumed per rising done.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (test_clock_w[g] === 1'b1 && mon_prev[g] !== 1'b1) edges[g]++;
      mon_prev[g] = test_clock_w[g];
      if (done_w[g] === 1'b1 && !done_seen[g]) begin
        done_seen[g] = 1'b1;
        if ((g == 0 && sb_q0.size() == 0) || (g == 1 && sb_q1.size() == 0)) begin
          checkOutput($sformatf("inst%0d_unexpected_done", g), 32'd1, 32'd0);
        end else begin
          e = (g == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
          checkOutput($sformatf("inst%0d_err_count", g), 32'(err_count_w[g]), e.errs);
          checkOutput($sformatf("inst%0d_first_err_step", g), 32'(first_err_step_w[g]), e.first_step);
          checkOutput($sformatf("inst%0d_first_err_data", g), 32'(first_err_data_w[g]), e.first_data);
          checkOutput($sformatf("inst%0d_pass", g), 32'(pass_w[g]), e.pass);
          checkOutput($sformatf("inst%0d_busy_low", g), 32'(busy_w[g]), 32'd0);
          checkOutput($sformatf("inst%0d_edges", g), edges[g], e.edges);
          checkOutput($sformatf("inst%0d_final_step", g), 32'(step_w[g]), e.final_step);
        end
        edges[g] = 0;
      end
      if (done_w[g] !== 1'b1) done_seen[g] = 1'b0;
      if (busy_w[g] !== 1'b1 && done_w[g] !== 1'b1) edges[g] = 0;
    end
  end

  task automatic checkIdle(input string tag);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("%s_inst%0d_busy", tag, g), 32'(busy_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_test_clock", tag, g), 32'(test_clock_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_done", tag, g), 32'(done_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_pass", tag, g), 32'(pass_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_err_count", tag, g), 32'(err_count_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_step", tag, g), 32'(step_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_grp_sel", tag, g), 32'(grp_sel_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_first_err_step", tag, g), 32'(first_err_step_w[g]), 32'd0);
      checkOutput($sformatf("%s_inst%0d_first_err_data", tag, g), 32'(first_err_data_w[g]), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] stuck, input int sa, input int sb,
                               input int abort_step, input int poke_step);
    bit finished;
    bit poked;
    int hold;
    stuck_mask = stuck;
    short_a    = sa;
    short_b    = sb;
    sb_q0.push_back(ref_run(128'h0));
    sb_q1.push_back(ref_run(skip1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finished = 1'b0;
    poked    = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (abort_step >= 0 && int'(step_w[0]) == abort_step) begin
        reset = 1'b1;
        @(negedge clk);
        checkIdle("abort");
        reset = 1'b0;
        sb_q0.delete();
        sb_q1.delete();
        return;
      end
      if (poke_step >= 0 && !poked && int'(step_w[0]) == poke_step) begin
        poked = 1'b1;
        hold  = int'(step_w[0]);
`ifdef PINTEST_CHECKER_STOP_ON_ERROR_EN
        if (done_w[1] === 1'b1) sb_q1.push_back(ref_run(skip1));
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("poke_busy_kept", 32'(busy_w[0]), 32'd1);
        checkOutput("poke_step_kept", 32'(int'(step_w[0]) == hold || int'(step_w[0]) == hold + 1), 32'd1);
      end
      if (done_w[0] === 1'b1 && done_w[1] === 1'b1 && busy_w[1] !== 1'b1) begin
        finished = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!finished) begin
      checkOutput("run_timeout", 32'd0, 32'd1);
      sb_q0.delete();
      sb_q1.delete();
    end
  endtask

  initial begin
    logic [127:0] one128;
    one128 = 128'h1;
    skip1  = one128 << 23;
    for (int g = 0; g < 2; g++) begin
      model_pos[g] = 0; model_low[g] = 0; model_prev[g] = 1'b0;
      edges[g] = 0; mon_prev[g] = 1'b0; done_seen[g] = 1'b0; sense_w[g] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;

    applyStimulus(128'h0, -1, -1, -1, -1);
    applyStimulus(one128 << 37, -1, -1, -1, -1);
    applyStimulus(128'h0, 5, 6, -1, -1);
    applyStimulus(one128 << 23, -1, -1, -1, -1);
    applyStimulus(128'h0, -1, -1, 50, -1);
    applyStimulus(128'h0, -1, -1, -1, 60);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(one128 << $urandom_range(0, 127), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 127)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
